// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with funct3 sizing, byte steering and fixed response latency
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned or unsupported accesses on resp_err
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_we;
    logic [2:0]    r_f3;
    logic [31:0]   r_addr, r_wdata, r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept, w_enter, w_we, w_sup, w_mis, w_ok, w_err;
    logic [2:0]    w_f3;
    logic [31:0]   w_addr, w_wdata, w_word, w_wd, w_load;
    logic [1:0]    w_a;
    logic [AW-1:0] w_idx;
    logic [3:0]    w_be;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    assign o_req_ready  = !i_rst && r_state != BUSY;
    assign o_resp_valid = r_state == RESP;
    assign o_resp_rdata = r_rdata;
    assign o_resp_err   = r_err;

    assign w_accept = i_req_valid && o_req_ready;
    assign w_enter  = (LATENCY == 1) ? w_accept : (r_state == BUSY && r_cnt == CW'(1));
    // With single-cycle latency the access happens on the accept edge, so use the live request
    assign w_we    = (LATENCY == 1) ? i_req_we     : r_we;
    assign w_f3    = (LATENCY == 1) ? i_req_funct3 : r_f3;
    assign w_addr  = (LATENCY == 1) ? i_req_addr   : r_addr;
    assign w_wdata = (LATENCY == 1) ? i_req_wdata  : r_wdata;

    assign w_a    = w_addr[1:0];
    assign w_idx  = w_addr[2 +: AW];
    assign w_word = r_mem[w_idx];
    assign w_sup  = (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b010) ||
                    (!w_we && (w_f3 == 3'b100 || w_f3 == 3'b101));
`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_mis = (w_f3[1:0] == 2'b01 && w_a[0]) || (w_f3 == 3'b010 && w_a != 2'b00);
    assign w_err = !w_sup || w_mis;
`else
    assign w_mis = 1'b0;
    assign w_err = 1'b0;
`endif
    assign w_ok = w_sup && !w_mis;

    assign w_be = (!w_ok || !w_we) ? 4'b0000 :
                  (w_f3 == 3'b000) ? 4'b0001 << w_a :
                  (w_f3 == 3'b001) ? (w_a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wd = (w_f3 == 3'b000) ? {4{w_wdata[7:0]}} :
                  (w_f3 == 3'b001) ? {2{w_wdata[15:0]}} : w_wdata;

    assign w_byte = w_word[{w_a, 3'b000} +: 8];
    assign w_half = w_a[1] ? w_word[31:16] : w_word[15:0];
    assign w_load = (!w_ok || w_we) ? 32'h0 :
                    (w_f3 == 3'b000) ? {{24{w_byte[7]}}, w_byte} :
                    (w_f3 == 3'b001) ? {{16{w_half[15]}}, w_half} :
                    (w_f3 == 3'b100) ? {24'h0, w_byte} :
                    (w_f3 == 3'b101) ? {16'h0, w_half} : w_word;

    always_ff @(posedge i_clk) begin
        if (w_enter && !i_rst)
            for (int b = 0; b < 4; b++)
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= (LATENCY == 1) ? RESP : BUSY;
                r_cnt   <= CW'(LATENCY - 1);
                r_we    <= i_req_we;
                r_f3    <= i_req_funct3;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
            end else if (r_state == BUSY) begin
                r_state <= (r_cnt == CW'(1)) ? RESP : BUSY;
                r_cnt   <= r_cnt - CW'(1);
            end else if (r_state == RESP) begin
                r_state <= IDLE;
            end
            if (w_enter) begin
                r_rdata <= w_load;
                r_err   <= w_err;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for dmem_responder at LATENCY=2, DEPTH_WORDS=64
module tb_dmem_responder;
    logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, we = 1'b0;
    logic [2:0]  f3 = 3'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, rvalid, err;
    logic [31:0] rdata;
    int          n_tests = 0, n_fail = 0;
    logic [32:0] sb [$];
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(valid), .o_req_ready(ready),
        .i_req_we(we), .i_req_funct3(f3), .i_req_addr(addr), .i_req_wdata(wdata),
        .o_resp_valid(rvalid), .o_resp_rdata(rdata), .o_resp_err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
        int c;
        logic [32:0] e;
        valid = 1'b1; we = w; f3 = f; addr = a; wdata = d;
        c = 0;
        while (!ready && c < 10) begin tick; c++; end
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: ready=%b, required 1", name, ready);
            valid = 1'b0;
            return;
        end
        sb.push_back({exp_err, exp_rd});
        tick;
        valid = 1'b0; we = ~w; f3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        c = 0;
        while (!rvalid && c < 8) begin tick; c++; end
        n_tests++;
        if (rvalid !== 1'b1 || c + 1 != 2) begin
            n_fail++;
            $display("FAIL %s latency: resp after %0d cycles (valid=%b), required 2", name, c + 1, rvalid);
        end
        if (rvalid === 1'b1) begin
            e = sb.pop_front();
            n_tests++;
            if ({err, rdata} !== e) begin
                n_fail++;
                $display("FAIL %s data: got err=%b rdata=%h, required err=%b rdata=%h", name, err, rdata, e[32], e[31:0]);
            end
        end
        tick;
        n_tests++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s pulse: resp_valid=%b one cycle later, required 0", name, rvalid);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        n_tests++;
        if ({ready, rvalid, err} !== 3'b000 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: ready=%b resp_valid=%b err=%b rdata=%h, required 0 0 0 00000000", ready, rvalid, err, rdata);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b, required 1", ready);
        end
        tick;
    endtask

    task automatic test_word;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, "sw_10");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, "lw_10");
    endtask

    task automatic test_byte;
        do_req(1'b1, 3'b000, 32'h13, 32'h12345680, 32'h0, 1'b0, "sb_13");
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, "lb_13");
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0, "lbu_13");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, "lw_10_after_sb");
    endtask

    task automatic test_half;
        do_req(1'b1, 3'b010, 32'h14, 32'h0, 32'h0, 1'b0, "sw_14_clear");
        do_req(1'b1, 3'b001, 32'h16, 32'hABCD8001, 32'h0, 1'b0, "sh_16");
        do_req(1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF8001, 1'b0, "lh_16");
        do_req(1'b0, 3'b101, 32'h16, 32'h0, 32'h00008001, 1'b0, "lhu_16");
        do_req(1'b0, 3'b010, 32'h114, 32'h0, 32'h80010000, 1'b0, "lw_114_alias");
    endtask

    task automatic test_back_to_back;
        int acc = 0, rsp = 0;
        logic [32:0] e;
        valid = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h10; wdata = 32'h0;
        for (int i = 0; i < 24; i++) begin
            if (i == 20) valid = 1'b0;
            if (i < 20) begin
                n_tests++;
                if (ready !== (i % 2 == 0)) begin
                    n_fail++;
                    $display("FAIL b2b ready cycle %0d: ready=%b, required %0d", i, ready, (i % 2 == 0));
                end
            end
            if (rvalid === 1'b1) begin
                rsp++;
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b unexpected response cycle %0d: rdata=%h, required none", i, rdata);
                end else begin
                    e = sb.pop_front();
                    if ({err, rdata} !== e) begin
                        n_fail++;
                        $display("FAIL b2b data cycle %0d: got err=%b rdata=%h, required err=%b rdata=%h", i, err, rdata, e[32], e[31:0]);
                    end
                end
            end
            if (valid && ready) begin
                acc++;
                sb.push_back({1'b0, 32'h80ADBEEF});
            end
            tick;
        end
        n_tests++;
        if (acc != 10 || rsp != 10) begin
            n_fail++;
            $display("FAIL b2b counts: accepts=%0d responses=%0d, required 10 10", acc, rsp);
        end
    endtask

    task automatic test_reset_mid;
        do_req(1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, 32'h0, 1'b0, "sw_20_prior");
        valid = 1'b1; we = 1'b1; f3 = 3'b010; addr = 32'h20; wdata = 32'h12345678;
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid accept: ready=%b, required 1", ready);
        end
        tick;
        valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (rvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_mid no_resp cycle %0d: resp_valid=%b, required 0", i, rvalid);
            end
            tick;
        end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'hA5A5A5A5, 1'b0, "lw_20_after_rst");
    endtask

    task automatic test_misalign;
        logic [31:0] w10;
        w10 = TRAP ? 32'h80ADBEEF : 32'hCAFEF00D;
        do_req(1'b0, 3'b010, 32'h11, 32'h0, TRAP ? 32'h0 : 32'h80ADBEEF, TRAP, "lw_11_misaligned");
        do_req(1'b1, 3'b010, 32'h11, 32'hCAFEF00D, 32'h0, TRAP, "sw_11_misaligned");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, w10, 1'b0, "lw_10_after_sw11");
        do_req(1'b0, 3'b001, 32'h11, 32'h0, TRAP ? 32'h0 : 32'hFFFFF00D, TRAP, "lh_11_misaligned");
        do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, TRAP, "ld_unsupported");
        do_req(1'b1, 3'b100, 32'h10, 32'h11111111, 32'h0, TRAP, "sbu_unsupported");
        do_req(1'b0, 3'b010, 32'h10, 32'h0, w10, 1'b0, "lw_10_after_sbu");
    endtask

    initial begin
        test_reset;
        test_word;
        test_byte;
        test_half;
        test_back_to_back;
        test_reset_mid;
        test_misalign;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
